// File: rtl/mux_scan_serializer_pkg.sv
// ----------------------------------------------------------------------------
// mux_scan_serializer_pkg
//   Shared definitions for the mux scan serializer:
//     - FSM state encodings (IDLE/SCAN/DONE/PAR)
//     - default mux-tree depth (NUM_LEVELS)
//     - helper functions deriving WIDTH and SEL_W from NUM_LEVELS
//   Optional feature macro: MUX_SCAN_SERIALIZER_PARITY_EN (PAR state in use).
// ----------------------------------------------------------------------------
package mux_scan_serializer_pkg;

  localparam int unsigned NUM_LEVELS_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2,
    PAR  = 2'd3
  } state_t;

  // Number of mux data inputs (and data word width) for a tree of n levels.
  function automatic int unsigned width_of(input int unsigned n);
    return 32'd1 << (n - 32'd1);
  endfunction

  // Select width for a tree of n levels.
  function automatic int unsigned sel_w_of(input int unsigned n);
    return n - 32'd1;
  endfunction

endpackage

// File: rtl/mux_scan_serializer_scan_counter.sv
// ----------------------------------------------------------------------------
// scan_counter
//   SEL_W-bit up counter that drives the mux select.
//   Ports:
//     clk   - clock, rising edge
//     rst   - synchronous active-high reset, clears count
//     clr   - synchronous clear (count <= 0)
//     en    - increment enable (wraps modulo 2**SEL_W)
//     count - current select value
//     tc    - terminal count, high when count is all ones
// ----------------------------------------------------------------------------
module scan_counter #(
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == '1);

endmodule

// File: rtl/mux_scan_serializer.sv
// ----------------------------------------------------------------------------
// mux_scan_serializer
//   Sequential front-end for a 2**(NUM_LEVELS-1):1 mux tree. On an accepted
//   start it latches data_in onto the mux data inputs, steps the select from 0
//   to WIDTH-1 one per clock, registers the returned mux output as an
//   LSB-first serial stream, reassembles it into word_out and flags a mismatch
//   against the latched word on completion.
//
//   Optional feature macro: MUX_SCAN_SERIALIZER_PARITY_EN
//     When defined, a PAR state follows SCAN and emits the even parity of the
//     latched word as a 17th valid serial bit before DONE.
//
//   Ports:
//     clk       - clock, rising edge
//     rst       - synchronous active-high reset, clears all state
//     start     - scan request, accepted only in IDLE
//     data_in   - word to serialize, sampled on the accepting edge
//     mux_in    - latched word, drives the mux data inputs
//     sel       - mux select
//     mux_out   - combinational mux output
//     ser_out   - registered serial bit
//     ser_valid - ser_out carries a valid bit
//     word_out  - reassembled word
//     busy      - scan in progress
//     done      - one-cycle completion pulse
//     mismatch  - word_out != mux_in at completion, held until next start
// ----------------------------------------------------------------------------
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter  int unsigned NUM_LEVELS = NUM_LEVELS_DEF,
  localparam int unsigned WIDTH      = width_of(NUM_LEVELS),
  localparam int unsigned SEL_W      = sel_w_of(NUM_LEVELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] sel,
  input  logic             mux_out,
  output logic             ser_out,
  output logic             ser_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  state_t state;
  state_t state_nxt;

  logic load;
  logic shift;
  logic finish;
  logic tc;
`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
  logic par_step;
`endif

  // --------------------------------------------------------------------------
  // Select counter: cleared on accept, advanced once per SCAN edge. It wraps
  // to 0 on the last SCAN edge, so no extra clear is needed afterwards.
  // --------------------------------------------------------------------------
  scan_counter #(
    .SEL_W(SEL_W)
  ) u_scan_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (shift),
    .count(sel),
    .tc   (tc)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (tc) begin
`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
      PAR:     state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: control decode
  // --------------------------------------------------------------------------
  always_comb begin
    load   = (state == IDLE) && start;
    shift  = (state == SCAN);
    finish = (state == DONE);
`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
    par_step = (state == PAR);
`endif
  end

  // --------------------------------------------------------------------------
  // Datapath: holding register, serial output, reassembly, comparator.
  // mux_out is sampled in the same cycle its select is presented, so the bit
  // captured on a SCAN edge belongs to the current (pre-increment) sel.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mux_in    <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      word_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      done <= 1'b0;

      if (load) begin
        mux_in   <= data_in;
        word_out <= '0;
        mismatch <= 1'b0;
        busy     <= 1'b1;
      end

      if (shift) begin
        ser_out       <= mux_out;
        word_out[sel] <= mux_out;
        ser_valid     <= 1'b1;
      end

`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
      if (par_step) begin
        ser_out   <= ^mux_in;
        ser_valid <= 1'b1;
      end
`endif

      if (finish) begin
        ser_valid <= 1'b0;
        done      <= 1'b1;
        busy      <= 1'b0;
        mismatch  <= (word_out != mux_in);
      end
    end
  end

endmodule
